// File: rtl/aes_pack.sv
// rtl/aes_pack.sv - AES block type, lookup tables and round helper functions
package aes_pack;

  localparam int DATA_WIDTH_IN_BYTES = 16;

  // Byte 0 sits in the top byte; byte 4*c+r is row r of column c.
  typedef logic [8*DATA_WIDTH_IN_BYTES-1:0] data_block;

  localparam logic [7:0] SUB_BYTES_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Entry 0 is never used; the schedule starts at index 1.
  localparam logic [7:0] RCON_TABLE [11] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic data_block sub_bytes(input data_block blk);
    data_block res;
    res = '0;
    for (int k = 0; k < DATA_WIDTH_IN_BYTES; k++)
      res[127-8*k -: 8] = SUB_BYTES_TABLE[blk[127-8*k -: 8]];
    return res;
  endfunction

  // Row r rotates left by r columns.
  function automatic data_block shift_rows(input data_block blk);
    data_block res;
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = blk[127-8*(4*((c+r)%4)+r) -: 8];
    return res;
  endfunction

  function automatic data_block mix_columns(input data_block blk);
    data_block res;
    logic [7:0] a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = blk[127-32*c -: 8];
      a1 = blk[119-32*c -: 8];
      a2 = blk[111-32*c -: 8];
      a3 = blk[103-32*c -: 8];
      res[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      res[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      res[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      res[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return res;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] res;
    res = '0;
    for (int k = 0; k < 4; k++)
      res[31-8*k -: 8] = SUB_BYTES_TABLE[w[31-8*k -: 8]];
    return res;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_iterative_encryptor_if.sv
// rtl/aes_iterative_encryptor_if.sv - plaintext/key input and ciphertext output handshake bundle
interface aes_iterative_encryptor_if #(
  parameter int KEY_WIDTH = 128
);
  import aes_pack::*;

  data_block              in_data;
  logic [KEY_WIDTH-1:0]   in_key;
  logic                   in_valid;
  logic                   in_ready;
  data_block              out_data;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output in_data, in_key, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_key, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - on-the-fly AES-128/256 round key generator, one round key per cycle
module aes_key_schedule
  import aes_pack::*;
#(
  parameter int KEY_WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 advance,
  input  logic [KEY_WIDTH-1:0] in_key,
  output data_block            round_key
);

  localparam int NK = KEY_WIDTH / 32;
  localparam logic [3:0] RCON_LAST = (NK == 8) ? 4'd7 : 4'd10;

  // Sliding window of the last NK expanded words; word 0 in the top bits.
  logic [KEY_WIDTH-1:0] key_window;
  logic [KEY_WIDTH-1:0] window_next;
  logic [3:0]           rcon_idx;
  logic                 first_pending;
  logic                 rot_step;
  logic [31:0]          temp;
  logic [31:0]          n0, n1, n2, n3;
  data_block            next_group;

  // Expand the next four words; AES-256 round 1 is the low half of the raw key.
  always_comb begin
    temp = rot_step ? (sub_word(rot_word(key_window[31:0])) ^ {RCON_TABLE[rcon_idx], 24'h000000})
                    : sub_word(key_window[31:0]);
    n0 = key_window[KEY_WIDTH-1  -: 32] ^ temp;
    n1 = key_window[KEY_WIDTH-33 -: 32] ^ n0;
    n2 = key_window[KEY_WIDTH-65 -: 32] ^ n1;
    n3 = key_window[KEY_WIDTH-97 -: 32] ^ n2;
    next_group = {n0, n1, n2, n3};
    round_key  = first_pending ? key_window[127:0] : next_group;
  end

  generate
    if (NK == 8) begin : g_window_256
      assign window_next = {key_window[127:0], next_group};
    end else begin : g_window_128
      assign window_next = next_group;
    end
  endgenerate

  // Load the cipher key on accept, then slide the window once per round.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_window    <= '0;
      rcon_idx      <= '0;
      first_pending <= 1'b0;
      rot_step      <= 1'b0;
    end else if (load) begin
      key_window    <= in_key;
      rcon_idx      <= 4'd1;
      first_pending <= (NK == 8);
      rot_step      <= 1'b1;
    end else if (advance) begin
      if (first_pending) begin
        first_pending <= 1'b0;
      end else begin
        key_window <= window_next;
        if (rot_step && rcon_idx != RCON_LAST)
          rcon_idx <= rcon_idx + 4'd1;
        rot_step <= (NK == 8) ? !rot_step : 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_iterative_encryptor.sv
// rtl/aes_iterative_encryptor.sv - one-round-per-cycle AES encryptor with valid/ready handshakes
module aes_iterative_encryptor
  import aes_pack::*;
#(
  parameter int KEY_WIDTH = 128
) (
  input logic                     clk,
  input logic                     rst,
  aes_iterative_encryptor_if.slave bus
);

  localparam int NUM_ROUNDS = (KEY_WIDTH == 256) ? 14 : 10;
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t IDLE  = 2'd0;
  localparam fsm_state_t ROUND = 2'd1;
  localparam fsm_state_t DONE  = 2'd2;

  fsm_state_t fsm;
  logic [3:0] round_cnt;
  data_block  state_reg;
  data_block  key0;
  data_block  round_key;
  data_block  shifted;
  data_block  round_out;
  logic       accept;
  logic       last_round;
  logic       advance;

  assign key0          = bus.in_key[KEY_WIDTH-1 -: 128];
  assign bus.in_ready  = !rst && ((fsm == IDLE) || (fsm == DONE && bus.out_ready));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (fsm == DONE);
  assign bus.out_data  = (fsm == DONE) ? state_reg : '0;
  assign last_round    = (round_cnt == LAST_ROUND);
  // The final round's key is not followed by another, so the schedule stops there.
  assign advance       = (fsm == ROUND) && !last_round;

  aes_key_schedule #(.KEY_WIDTH(KEY_WIDTH)) u_key_schedule (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .advance   (advance),
    .in_key    (bus.in_key),
    .round_key (round_key)
  );

  // One full AES round on the held state; the last round skips MixColumns.
  always_comb begin
    shifted   = shift_rows(sub_bytes(state_reg));
    round_out = (last_round ? shifted : mix_columns(shifted)) ^ round_key;
  end

  // Control FSM: accept in IDLE or on a DONE handshake, iterate rounds, hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      round_cnt <= '0;
      state_reg <= '0;
    end else begin
      case (fsm)
        IDLE, DONE: begin
          if (accept) begin
            state_reg <= bus.in_data ^ key0;
            round_cnt <= 4'd1;
            fsm       <= ROUND;
          end else if (fsm == DONE && bus.out_ready) begin
            state_reg <= '0;
            round_cnt <= '0;
            fsm       <= IDLE;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          round_cnt <= round_cnt + 4'd1;
          if (last_round)
            fsm <= DONE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iterative_encryptor.sv
// tb/tb_aes_iterative_encryptor.sv - directed-vector bench for the AES-128 and AES-256 encryptor
module tb_aes_iterative_encryptor;
  import aes_pack::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  aes_iterative_encryptor_if #(.KEY_WIDTH(128)) bus128 ();
  aes_iterative_encryptor_if #(.KEY_WIDTH(256)) bus256 ();

  aes_iterative_encryptor #(.KEY_WIDTH(128)) dut128 (.clk(clk), .rst(rst), .bus(bus128));
  aes_iterative_encryptor #(.KEY_WIDTH(256)) dut256 (.clk(clk), .rst(rst), .bus(bus256));

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_A  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_A  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_B  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out128(output int cycles);
    cycles = 0;
    while (!bus128.out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus128.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready128 got %b exp 0", bus128.in_ready); end
    checks++; if (bus256.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready256 got %b exp 0", bus256.in_ready); end
    checks++; if (bus128.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid128 got %b exp 0", bus128.out_valid); end
    checks++; if (bus128.out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data128 got %h exp 0", bus128.out_data); end
    checks++; if (bus256.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid256 got %b exp 0", bus256.out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (bus128.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready128 got %b exp 1", bus128.in_ready); end
    checks++; if (bus256.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready256 got %b exp 1", bus256.in_ready); end
  endtask

  task automatic test_vectors128();
    logic [127:0] pts [3];
    logic [127:0] keys [3];
    logic [127:0] cts [3];
    int cyc;
    pts  = '{PT_A, PT_B, 128'h0};
    keys = '{KEY_A, KEY_B, 128'h0};
    cts  = '{CT_A, CT_B, CT_Z};
    for (int i = 0; i < 3; i++) begin
      bus128.in_data   = pts[i];
      bus128.in_key    = keys[i];
      bus128.in_valid  = 1'b1;
      bus128.out_ready = 1'b0;
      #1;
      checks++; if (bus128.in_ready !== 1'b1) begin errors++; $display("FAIL vec%0d_idle_ready got %b exp 1", i, bus128.in_ready); end
      tick();
      bus128.in_valid = 1'b0;
      bus128.in_data  = ~pts[i];
      bus128.in_key   = ~keys[i];
      #1;
      checks++; if (bus128.in_ready !== 1'b0) begin errors++; $display("FAIL vec%0d_round_ready got %b exp 0", i, bus128.in_ready); end
      wait_out128(cyc);
      checks++; if (cyc != 10) begin errors++; $display("FAIL vec%0d_latency got %0d exp 10", i, cyc); end
      checks++; if (bus128.out_data !== cts[i]) begin errors++; $display("FAIL vec%0d_ct got %h exp %h", i, bus128.out_data, cts[i]); end
      bus128.out_ready = 1'b1;
      tick();
      bus128.out_ready = 1'b0;
      checks++; if (bus128.out_valid !== 1'b0 || bus128.out_data !== 128'h0) begin errors++; $display("FAIL vec%0d_idle_out got %b/%h exp 0/0", i, bus128.out_valid, bus128.out_data); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bus128.in_data  = PT_A;
    bus128.in_key   = KEY_A;
    bus128.in_valid = 1'b1;
    tick();
    bus128.in_valid = 1'b0;
    wait_out128(cyc);
    checks++; if (cyc != 10) begin errors++; $display("FAIL b2b_first_latency got %0d exp 10", cyc); end
    bus128.in_data  = PT_B;
    bus128.in_key   = KEY_B;
    bus128.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus128.out_valid !== 1'b1 || bus128.out_data !== CT_A) begin errors++; $display("FAIL hold%0d_out got %b/%h exp 1/%h", i, bus128.out_valid, bus128.out_data, CT_A); end
      checks++; if (bus128.in_ready !== 1'b0) begin errors++; $display("FAIL hold%0d_in_ready got %b exp 0", i, bus128.in_ready); end
      tick();
    end
    bus128.out_ready = 1'b1;
    #1;
    checks++; if (bus128.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", bus128.in_ready); end
    tick();
    bus128.out_ready = 1'b0;
    bus128.in_valid  = 1'b0;
    bus128.in_data   = 128'h0;
    checks++; if (bus128.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_bubble got %b exp 0", bus128.out_valid); end
    wait_out128(cyc);
    checks++; if (cyc != 10) begin errors++; $display("FAIL b2b_second_latency got %0d exp 10", cyc); end
    checks++; if (bus128.out_data !== CT_B) begin errors++; $display("FAIL b2b_second_ct got %h exp %h", bus128.out_data, CT_B); end
    bus128.out_ready = 1'b1;
    tick();
    bus128.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_round();
    int cyc;
    int seen;
    bus128.in_data  = PT_A;
    bus128.in_key   = KEY_A;
    bus128.in_valid = 1'b1;
    tick();
    bus128.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus128.out_valid !== 1'b0 || bus128.out_data !== 128'h0) begin errors++; $display("FAIL midrst_out got %b/%h exp 0/0", bus128.out_valid, bus128.out_data); end
    checks++; if (bus128.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", bus128.in_ready); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus128.out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midrst_discard got %0d exp 0", seen); end
    bus128.in_data  = PT_B;
    bus128.in_key   = KEY_B;
    bus128.in_valid = 1'b1;
    tick();
    bus128.in_valid = 1'b0;
    wait_out128(cyc);
    checks++; if (cyc != 10 || bus128.out_data !== CT_B) begin errors++; $display("FAIL midrst_fresh got %0d/%h exp 10/%h", cyc, bus128.out_data, CT_B); end
    bus128.out_ready = 1'b1;
    tick();
    bus128.out_ready = 1'b0;
  endtask

  task automatic test_random_in_valid();
    logic [127:0] pts [4];
    logic [127:0] keys [4];
    logic [127:0] cts [4];
    int cyc;
    int extra;
    pts  = '{PT_B, PT_A, 128'h0, PT_A};
    keys = '{KEY_B, KEY_A, 128'h0, KEY_A};
    cts  = '{CT_B, CT_A, CT_Z, CT_A};
    for (int b = 0; b < 4; b++) begin
      bus128.in_data  = pts[b];
      bus128.in_key   = keys[b];
      bus128.in_valid = 1'b1;
      tick();
      cyc = 0;
      while (!bus128.out_valid && cyc < 40) begin
        bus128.in_valid = 1'($urandom_range(0, 1));
        bus128.in_data  = {$urandom, $urandom, $urandom, $urandom};
        bus128.in_key   = {$urandom, $urandom, $urandom, $urandom};
        tick();
        cyc++;
      end
      bus128.in_valid = 1'b0;
      checks++; if (cyc != 10) begin errors++; $display("FAIL rand%0d_latency got %0d exp 10", b, cyc); end
      checks++; if (bus128.out_data !== cts[b]) begin errors++; $display("FAIL rand%0d_ct got %h exp %h", b, bus128.out_data, cts[b]); end
      bus128.out_ready = 1'b1;
      tick();
      bus128.out_ready = 1'b0;
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        if (bus128.out_valid) extra++;
        tick();
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL rand%0d_single_result got %0d extra exp 0", b, extra); end
    end
  endtask

  task automatic test_aes256();
    int cyc;
    bus256.in_data   = PT_B;
    bus256.in_key    = KEY_256;
    bus256.in_valid  = 1'b1;
    bus256.out_ready = 1'b0;
    tick();
    bus256.in_valid = 1'b0;
    bus256.in_data  = ~PT_B;
    bus256.in_key   = ~KEY_256;
    cyc = 0;
    while (!bus256.out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    checks++; if (cyc != 14) begin errors++; $display("FAIL aes256_latency got %0d exp 14", cyc); end
    checks++; if (bus256.out_data !== CT_256) begin errors++; $display("FAIL aes256_ct got %h exp %h", bus256.out_data, CT_256); end
    tick();
    checks++; if (bus256.out_valid !== 1'b1 || bus256.out_data !== CT_256) begin errors++; $display("FAIL aes256_hold got %b/%h exp 1/%h", bus256.out_valid, bus256.out_data, CT_256); end
    bus256.out_ready = 1'b1;
    tick();
    bus256.out_ready = 1'b0;
    checks++; if (bus256.out_valid !== 1'b0 || bus256.out_data !== 128'h0) begin errors++; $display("FAIL aes256_release got %b/%h exp 0/0", bus256.out_valid, bus256.out_data); end
  endtask

  initial begin
    rst              = 1'b1;
    bus128.in_data   = '0;
    bus128.in_key    = '0;
    bus128.in_valid  = 1'b0;
    bus128.out_ready = 1'b0;
    bus256.in_data   = '0;
    bus256.in_key    = '0;
    bus256.in_valid  = 1'b0;
    bus256.out_ready = 1'b0;
    test_reset();
    test_vectors128();
    test_back_to_back();
    test_reset_mid_round();
    test_random_in_valid();
    test_aes256();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_iterative_encryptor.md
AES_ITERATIVE_ENCRYPTOR -- requirements
Module: aes_iterative_encryptor

Interface
REQ-001 Parameter KEY_WIDTH, default 128, cipher key width in bits; legal values 128 and 256 only.
REQ-002 Derived localparam NUM_ROUNDS: 10 when KEY_WIDTH=128, 14 when KEY_WIDTH=256.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  128  plaintext block.
REQ-006 in_key  input  KEY_WIDTH  cipher key.
REQ-007 in_valid  input  1  in_data/in_key valid.
REQ-008 in_ready  output  1  block ready to accept a new plaintext.
REQ-009 out_data  output  128  ciphertext block.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts out_data.

Function
REQ-012 The block SHALL implement FIPS-197 AES encryption; byte 0 of every 128-bit block and key maps to bits [MSB:MSB-7], column-major state order.
REQ-013 Accept occurs on a rising edge with in_valid=1 and in_ready=1; in_data and in_key SHALL be sampled only at accept.
REQ-014 FSM states: IDLE, ROUND, DONE; reset state IDLE.
REQ-015 IDLE: in_ready=1, out_valid=0; on accept, state <= in_data XOR round key 0, round counter <= 1, go to ROUND.
REQ-016 ROUND: in_ready=0; each cycle applies one round (SubBytes, ShiftRows, MixColumns, AddRoundKey) and increments the counter.
REQ-017 Round NUM_ROUNDS SHALL omit MixColumns; after it, go to DONE.
REQ-018 Latency: out_valid SHALL rise exactly NUM_ROUNDS cycles after the accept edge (10 or 14).
REQ-019 DONE: out_valid=1, out_data stable until a handshake (out_valid & out_ready).
REQ-020 DONE: in_ready = out_ready; simultaneous output handshake and input accept SHALL go directly to ROUND with the new block (back-to-back, no IDLE bubble).
REQ-021 DONE with out_ready=1 and in_valid=0 SHALL go to IDLE.
REQ-022 in_valid changes while in ROUND SHALL be ignored; no block lost or corrupted.
REQ-023 Round keys SHALL be generated on the fly, one 128-bit round key per cycle; no full key-schedule storage.
REQ-024 KEY_WIDTH=128: key window of 4 words; each round applies RotWord, SubWord, Rcon[r] to the last word.
REQ-025 KEY_WIDTH=256: key window of 8 words; round keys 0 and 1 come directly from in_key; subsequent 4-word groups alternate RotWord+SubWord+Rcon and SubWord only, per FIPS-197.
REQ-026 Rcon index SHALL advance only on RotWord steps: 1..10 for 128, 1..7 for 256; never out of range.
REQ-027 out_data SHALL read 0 whenever out_valid=0.

Reset
REQ-028 rst=1 at any edge, including mid-ROUND or DONE, SHALL force IDLE, round counter 0, state/key registers 0, out_valid=0, out_data=0; in-flight block discarded.
REQ-029 in_ready SHALL be 0 during a cycle with rst=1 and 1 on the first cycle after rst deasserts.

Structure
REQ-030 Package aes_pack SHALL hold: DATA_WIDTH_IN_BYTES, data_block typedef, SUB_BYTES_TABLE, RCON_TABLE, and functions sub_bytes, shift_rows, mix_columns, sub_word, rot_word.
REQ-031 The FSM/state enum type SHALL be local to the module.
REQ-032 One sub-module aes_key_schedule (KEY_WIDTH parameter; load, advance, round_key outputs) SHALL contain REQ-023..026.

Verification
REQ-033 KEY_WIDTH=128, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32, out_valid 10 cycles after accept.
REQ-034 KEY_WIDTH=128, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-035 KEY_WIDTH=256, key 000102...1e1f, pt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089, out_valid 14 cycles after accept.
REQ-036 out_ready held 0 for 5 cycles in DONE -> out_data/out_valid stable; in_ready=0 throughout; then out_ready=1 with in_valid=1 -> second block accepted same edge, correct result 10 cycles later.
REQ-037 rst pulsed at round 5 -> next cycle out_valid=0, in_ready=1; fresh block afterwards yields correct ciphertext.
REQ-038 in_valid toggled randomly during ROUND -> exactly one result per accepted block, all matching the reference model.
